fp_addsub_sequencer: RTL and testbench
======================================

Name: fp_addsub_sequencer

Overview:
- Front-end and back-end for the multi-cycle IEEE754 single-precision add/sub core.
- Queues operation requests in a small FIFO and resolves special operands (zero, Inf, NaN) locally without using the core.
- Issues ordinary operands to the core with a one-cycle start pulse, waits for the core's busy/ready sequence, and captures the result into a valid/ready output register.

Parameters:
- DEPTH, 4: request FIFO entries (power of two, ≥2).
- TIMEOUT, 255: maximum cycles to wait on the core before an error result is returned.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO not full.
- in_op  in  1  1 = add (a+b), 0 = subtract (a-b); same encoding as the core's op.
- in_a  in  32  operand A, IEEE754 single.
- in_b  in  32  operand B, IEEE754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  result word.
- out_err  out  1  result produced by timeout.
- core_start  out  1  start pulse to core.
- core_op  out  1  op to core.
- core_a  out  32  operand A to core.
- core_b  out  32  operand B to core.
- core_busy  in  1  core busy.
- core_ready  in  1  core idle.
- core_data  in  32  core result; meaningful only while core_ready=1.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- seq_busy  out  1  sequencer state is not IDLE.

Behaviour:
- Reset: synchronous, active-high; clock and reset are the only clocking/reset inputs.
  - Reset values: FIFO empty, fifo_level=0, in_ready=1, out_valid=0, out_data=0, out_err=0, core_start=0, core_op=0, core_a=0, core_b=0, seq_busy=0, state=IDLE, timeout counter=0.
  - Reset mid-operation discards the FIFO contents and any in-flight request. The core is not informed; the next issue waits for core_ready=1 before pulsing start.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, registered-based; a pop in the same cycle does not admit a push into a full FIFO.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- Pop condition: state=IDLE, FIFO non-empty, out_valid=0 (strictly serialized), and core_ready=1. The popped entry is latched into core_op/core_a/core_b, which are held stable until the next pop.
- Classification on pop (combinational on the head entry). Define eff_sb = b.sign XOR !op.
  - NaN: either operand has exp=255 and frac≠0 -> 0x7FC00000.
  - Inf: both operands Inf with a.sign≠eff_sb -> 0x7FC00000.
  - Inf: otherwise, A Inf -> a; otherwise, B Inf -> {eff_sb, b[30:0]}.
  - Zero: both zero (exp=0, frac=0) -> {a.sign & eff_sb, 31'b0}.
  - Zero: only B zero -> a; only A zero -> {eff_sb, b[30:0]}.
  - Denormals (exp=0, frac≠0) are not special; they are issued to the core.
- State machine:
  - IDLE: on pop, go to BYPASS if the entry is special, else ISSUE.
  - BYPASS (1 cycle): out_data = special result, out_valid=1, out_err=0; go to IDLE. Result is visible 2 cycles after pop.
  - ISSUE (1 cycle): core_start=1; clear counter; go to WAIT_BUSY.
  - WAIT_BUSY: go to RUN when core_busy=1.
  - RUN: when core_busy=0 && core_ready=1, go to CAPTURE.
  - CAPTURE (1 cycle): out_data=core_data, out_valid=1, out_err=0; go to IDLE.
- core_start is high for exactly one cycle per issued request and never in any other state.
- Timeout:
  - The counter increments every cycle in WAIT_BUSY and RUN.
  - When the counter reaches TIMEOUT: out_data=0x7FC00000, out_err=1, out_valid=1, go to IDLE.
  - The counter saturates and never wraps.
- Output register: out_valid clears on out_valid && out_ready. out_data and out_err are held stable while out_valid=1 && !out_ready.
- seq_busy=1 whenever state≠IDLE.

Test Plan:
- Core model with 40-cycle latency; push op=1, a=0x3F800000, b=0x40000000 -> exactly one core_start pulse; out_data=0x40400000, out_err=0.
- Push op=1, a=0x80000000, b=0x00000000 -> core_start never asserted; out_data=0x00000000 two cycles after pop. Repeat with a=0x80000000, b=0x80000000 -> 0x80000000.
- op=0, a=0x7F800000, b=0x7F800000 -> 0x7FC00000. op=1, a=0x3F800000, b=0x7FC00001 -> 0x7FC00000. Neither issues to the core.
- out_ready=0; push 6 requests back-to-back -> first reaches the output register; next 4 fill the FIFO (fifo_level=4, in_ready=0); 6th is not accepted until out_ready=1 drains one entry.
- core_busy tied 0 -> after TIMEOUT=255 cycles in WAIT_BUSY: out_valid=1, out_err=1, out_data=0x7FC00000; the next request proceeds normally.
- Assert reset for 1 cycle while in RUN with 3 entries queued -> next cycle all outputs at reset values, fifo_level=0; a subsequent request completes correctly.

Source files
------------

// File: rtl/fp_addsub_sequencer_if.sv
// Request, result and core-side handshake bundle for fp_addsub_sequencer.
// slave is the sequencer's view; master is the surrounding environment.
interface fp_addsub_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        core_start;
    logic        core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_busy;
    logic        core_ready;
    logic [31:0] core_data;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
               core_busy, core_ready, core_data,
        output in_ready, out_valid, out_data, out_err,
               core_start, core_op, core_a, core_b
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
               core_busy, core_ready, core_data,
        input  in_ready, out_valid, out_data, out_err,
               core_start, core_op, core_a, core_b
    );
endinterface

// File: rtl/fp_addsub_sequencer.sv
// Request FIFO, special-operand bypass and issue/capture sequencer wrapped
// around a multi-cycle IEEE754 single-precision add/sub core.
module fp_addsub_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    fp_addsub_sequencer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     seq_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE, S_BYPASS, S_ISSUE, S_WAIT_BUSY, S_RUN, S_CAPTURE
    } state_t;

    logic [64:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_spec_res;
    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic          r_out_err;
    logic          r_core_start;
    logic          r_core_op;
    logic [31:0]   r_core_a;
    logic [31:0]   r_core_b;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_op;
    logic [31:0]   w_a;
    logic [31:0]   w_b;
    logic          w_eff_sb;
    logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic          w_special;
    logic [31:0]   w_spec_res;
    logic          w_timeout;
    logic [CW-1:0] w_cnt_inc;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    // One result in flight at a time: no pop while the output register is occupied.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !r_out_valid && bus.core_ready;

    assign {w_op, w_a, w_b} = r_mem[r_rd_ptr];

    assign w_a_nan  = (w_a[30:23] == 8'hFF) && (w_a[22:0] != '0);
    assign w_b_nan  = (w_b[30:23] == 8'hFF) && (w_b[22:0] != '0);
    assign w_a_inf  = (w_a[30:23] == 8'hFF) && (w_a[22:0] == '0);
    assign w_b_inf  = (w_b[30:23] == 8'hFF) && (w_b[22:0] == '0);
    assign w_a_zero = (w_a[30:0] == '0);
    assign w_b_zero = (w_b[30:0] == '0);
    assign w_eff_sb = w_b[31] ^ ~w_op;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = QNAN;
        if (w_a_nan || w_b_nan)
            w_spec_res = QNAN;
        else if (w_a_inf && w_b_inf && (w_a[31] != w_eff_sb))
            w_spec_res = QNAN;
        else if (w_a_inf)
            w_spec_res = w_a;
        else if (w_b_inf)
            w_spec_res = {w_eff_sb, w_b[30:0]};
        else if (w_a_zero && w_b_zero)
            w_spec_res = {w_a[31] & w_eff_sb, 31'b0};
        else if (w_b_zero)
            w_spec_res = w_a;
        else if (w_a_zero)
            w_spec_res = {w_eff_sb, w_b[30:0]};
        else
            w_special = 1'b0;
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT));
    assign w_cnt_inc = w_timeout ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus.in_op, bus.in_a, bus.in_b};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_spec_res   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_core_start <= 1'b0;
            r_core_op    <= 1'b0;
            r_core_a     <= '0;
            r_core_b     <= '0;
        end else begin
            if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_core_op  <= w_op;
                        r_core_a   <= w_a;
                        r_core_b   <= w_b;
                        r_spec_res <= w_spec_res;
                        if (w_special) begin
                            r_state <= S_BYPASS;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                S_BYPASS: begin
                    r_out_data  <= r_spec_res;
                    r_out_err   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ISSUE: begin
                    r_core_start <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_out_data  <= QNAN;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_state == S_WAIT_BUSY) begin
                        if (bus.core_busy)
                            r_state <= S_RUN;
                    end else if (!bus.core_busy && bus.core_ready) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_out_data  <= bus.core_data;
                    r_out_err   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_err    = r_out_err;
    assign bus.core_start = r_core_start;
    assign bus.core_op    = r_core_op;
    assign bus.core_a     = r_core_a;
    assign bus.core_b     = r_core_b;
    assign fifo_level     = r_count;
    assign seq_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed self-checking bench for fp_addsub_sequencer with a behavioural
// 40-cycle core model that can also be made to never assert busy.
module tb_fp_addsub_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fifo_level;
    logic       seq_busy;

    fp_addsub_sequencer_if bus();

    fp_addsub_sequencer #(.DEPTH(4), .TIMEOUT(255)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .seq_busy   (seq_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Core model: busy one cycle after start, result after 40 cycles.
    // In stuck mode busy never rises and ready returns after 300 cycles.
    logic        stuck       = 1'b0;
    logic [31:0] core_result = '0;
    logic        m_busy      = 1'b0;
    logic        m_ready     = 1'b1;
    logic [31:0] m_data      = '0;
    logic [9:0]  m_cnt       = '0;
    int          start_cnt   = 0;

    assign bus.core_busy  = m_busy;
    assign bus.core_ready = m_ready;
    assign bus.core_data  = m_data;

    always @(posedge clock) begin
        if (bus.core_start) begin
            start_cnt <= start_cnt + 1;
            m_ready   <= 1'b0;
            m_busy    <= !stuck;
            m_cnt     <= stuck ? 10'd300 : 10'd40;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1'b1;
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_data  <= core_result;
            end
        end
    end

    task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        while (!bus.in_ready && n < 1000) begin @(negedge clock); n++; end
        n_checks++;
        if (n >= 1000) begin n_fail++; $display("FAIL push_accept: in_ready stuck at %b, required 1", bus.in_ready); end
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit, output int n);
        n = 0;
        while (!bus.out_valid && n < limit) begin @(negedge clock); n++; end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.core_start, bus.core_op, seq_busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL %s_flags: {in_ready,out_valid,out_err,core_start,core_op,seq_busy}=%b required 100000", tag,
                     {bus.in_ready, bus.out_valid, bus.out_err, bus.core_start, bus.core_op, seq_busy});
        end
        n_checks++;
        if ({bus.out_data, bus.core_a, bus.core_b} !== 96'h0) begin
            n_fail++;
            $display("FAIL %s_words: out_data=%h core_a=%h core_b=%h required all zero", tag, bus.out_data, bus.core_a, bus.core_b);
        end
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL %s_level: fifo_level=%0d required 0", tag, fifo_level); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_issue();
        int s0, n;
        s0 = start_cnt;
        core_result = 32'h40400000;
        push(1'b1, 32'h3F800000, 32'h40000000);
        @(negedge clock);
        n_checks++;
        if ({bus.core_start, seq_busy, bus.core_op, bus.core_a, bus.core_b} !== {3'b111, 32'h3F800000, 32'h40000000}) begin
            n_fail++;
            $display("FAIL issue_start: start=%b busy=%b op=%b a=%h b=%h required 1 1 1 3f800000 40000000",
                     bus.core_start, seq_busy, bus.core_op, bus.core_a, bus.core_b);
        end
        @(negedge clock);
        n_checks++;
        if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL issue_pulse: core_start=%b required 0", bus.core_start); end
        wait_out(200, n);
        n_checks++;
        if (n >= 200 || bus.out_data !== 32'h40400000 || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_result: valid=%b data=%h err=%b required 1 40400000 0", bus.out_valid, bus.out_data, bus.out_err);
        end
        n_checks++;
        if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL issue_starts: %0d start pulses required 1", start_cnt - s0); end
        consume();
        n_checks++;
        if (bus.core_a !== 32'h3F800000) begin n_fail++; $display("FAIL issue_hold: core_a=%h required 3f800000", bus.core_a); end

        // Denormal operand is ordinary work for the core.
        s0 = start_cnt;
        core_result = 32'h3F800001;
        push(1'b1, 32'h00000001, 32'h3F800000);
        wait_out(200, n);
        n_checks++;
        if (n >= 200 || bus.out_data !== 32'h3F800001 || start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL denormal_issue: data=%h starts=%0d required 3f800001 1", bus.out_data, start_cnt - s0);
        end
        consume();
    endtask

    task automatic test_bypass();
        logic        t_op  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] t_a   [7] = '{32'h80000000, 32'h80000000, 32'h7F800000, 32'h3F800000,
                                   32'h3F800000, 32'h00000000, 32'hFF800000};
        logic [31:0] t_b   [7] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00001,
                                   32'h7F800000, 32'h3F800000, 32'h3F800000};
        logic [31:0] t_exp [7] = '{32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
                                   32'hFF800000, 32'hBF800000, 32'hFF800000};
        int s0;
        for (int i = 0; i < 7; i++) begin
            s0 = start_cnt;
            push(t_op[i], t_a[i], t_b[i]);
            @(negedge clock);
            n_checks++;
            if (bus.out_valid !== 1'b0 || seq_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bypass%0d_early: out_valid=%b seq_busy=%b required 0 1", i, bus.out_valid, seq_busy);
            end
            @(negedge clock);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== t_exp[i] || bus.out_err !== 1'b0 || bus.core_a !== t_a[i]) begin
                n_fail++;
                $display("FAIL bypass%0d_result: valid=%b data=%h err=%b core_a=%h required 1 %h 0 %h",
                         i, bus.out_valid, bus.out_data, bus.out_err, bus.core_a, t_exp[i], t_a[i]);
            end
            n_checks++;
            if (start_cnt != s0) begin n_fail++; $display("FAIL bypass%0d_nostart: %0d start pulses required 0", i, start_cnt - s0); end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_op = 1'b1; bus.in_a = 32'h3F800000 + i; bus.in_b = 32'h0;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: in_ready=%b required 1", i, bus.in_ready); end
            @(negedge clock);
        end
        bus.in_a = 32'h3F800005;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({fifo_level, bus.in_ready, bus.out_valid} !== {3'd4, 2'b01} || bus.out_data !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL b2b_full: level=%0d in_ready=%b out_valid=%b data=%h required 4 0 1 3f800000",
                     fifo_level, bus.in_ready, bus.out_valid, bus.out_data);
        end
        consume();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain1: in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b1 || fifo_level !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_pop: in_ready=%b level=%0d required 1 3", bus.in_ready, fifo_level);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_sixth: level=%0d required 4", fifo_level); end
        for (int i = 1; i < 6; i++) begin
            wait_out(20, n);
            n_checks++;
            if (n >= 20 || bus.out_data !== 32'h3F800000 + i) begin
                n_fail++;
                $display("FAIL b2b_order%0d: valid=%b data=%h required 1 %h", i, bus.out_valid, bus.out_data, 32'h3F800000 + i);
            end
            consume();
        end
    endtask

    task automatic test_timeout();
        int s0, n;
        stuck = 1'b1;
        s0 = start_cnt;
        push(1'b1, 32'h3F800000, 32'h40000000);
        wait_out(400, n);
        n_checks++;
        if (n !== 258) begin n_fail++; $display("FAIL timeout_latency: %0d cycles required 258", n); end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_data !== 32'h7FC00000 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: valid=%b err=%b data=%h seq_busy=%b required 1 1 7fc00000 0",
                     bus.out_valid, bus.out_err, bus.out_data, seq_busy);
        end
        n_checks++;
        if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL timeout_starts: %0d pulses required 1", start_cnt - s0); end
        stuck = 1'b0;
        consume();
        core_result = 32'h40400000;
        push(1'b1, 32'h3F800000, 32'h40000000);
        wait_out(600, n);
        n_checks++;
        if (n >= 600 || bus.out_data !== 32'h40400000 || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover: valid=%b data=%h err=%b required 1 40400000 0", bus.out_valid, bus.out_data, bus.out_err);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int s0, n;
        core_result = 32'h40400000;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_op = 1'b1; bus.in_a = 32'h3F800000; bus.in_b = 32'h40000000;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.core_busy && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        n_checks++;
        if (n >= 50 || fifo_level !== 3'd3 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_setup: core_busy=%b level=%0d seq_busy=%b required 1 3 1", bus.core_busy, fifo_level, seq_busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_values("midrun_reset");
        s0 = start_cnt;
        push(1'b1, 32'h3F800000, 32'h40000000);
        wait_out(300, n);
        n_checks++;
        if (n >= 300 || bus.out_data !== 32'h40400000 || bus.out_err !== 1'b0 || start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL midrun_after: valid=%b data=%h err=%b starts=%0d required 1 40400000 0 1",
                     bus.out_valid, bus.out_data, bus.out_err, start_cnt - s0);
        end
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_issue();
        test_bypass();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
        $fatal(1);
    end
endmodule
